// File: rtl/output_serializer.sv
// Framed serial transmitter for the SAP output register: idle-high line carrying a start bit,
// WIDTH data bits LSB-first and a stop bit, each held for BIT_CYCLES clocks.
module output_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CycW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);
  localparam logic [CycW-1:0] LastCyc = CycW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shreg_shifted;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CycW-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end       = (cyc_cnt_q == LastCyc);
  assign shreg_shifted = shreg_q >> 1;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // tx is computed one cycle ahead so the line comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    cyc_cnt_d = (state_q == StIdle || bit_end) ? '0 : cyc_cnt_q + CycW'(1);
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (load) begin
          shreg_d   = data_in;
          bit_cnt_d = '0;
          state_d   = StStart;
          tx_d      = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shreg_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == LastBit) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            shreg_d   = shreg_shifted;
            bit_cnt_d = bit_cnt_q + BitW'(1);
            tx_d      = shreg_shifted[0];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx    = tx_q;
    done  = done_q;
    ready = (state_q == StIdle);
    busy  = (state_q != StIdle);
  end

endmodule

// File: tb/tb_output_serializer.sv
// Bench for output_serializer: a line monitor rebuilds each frame and checks it against words
// queued when loads are issued; a second instance covers the BIT_CYCLES=1 build.
module tb_output_serializer;

  logic       clk;
  logic       clear;
  logic       load, load1;
  logic [7:0] data_in, data1;
  logic       tx, ready, busy, done;
  logic       tx1, ready1, busy1, done1;

  int n_vec;
  int n_err;
  int n_done;
  int cyc;
  logic [7:0] exp_q[$];
  int starts[$];

  output_serializer #(.WIDTH(8), .BIT_CYCLES(4)) dut (
    .clk     (clk),
    .clear   (clear),
    .load    (load),
    .data_in (data_in),
    .tx      (tx),
    .ready   (ready),
    .busy    (busy),
    .done    (done)
  );

  output_serializer #(.WIDTH(8), .BIT_CYCLES(1)) dut1 (
    .clk     (clk),
    .clear   (clear),
    .load    (load1),
    .data_in (data1),
    .tx      (tx1),
    .ready   (ready1),
    .busy    (busy1),
    .done    (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial n_done = 0;
  always @(negedge clk) if (done === 1'b1) n_done = n_done + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line samples for one frame, index = cycle after the accepting edge.
  function automatic logic [39:0] frame_bits(input logic [7:0] w, input int bc);
    logic [39:0] v;
    logic        b;
    v = '0;
    for (int i = 0; i < 10; i++) begin
      b = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : w[i-1];
      for (int c = 0; c < bc; c++) v[i*bc+c] = b;
    end
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    data_in = w;
    load    = 1'b1;
    exp_q.push_back(w);
    step();
    load = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (done !== 1'b1 && n < 100);
    chk({tag, "_done_seen"}, done, 1'b1);
  endtask

  initial begin : monitor
    logic [39:0] got;
    logic [7:0]  w;
    bit          aborted;
    bit          bad_ctl;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && clear !== 1'b1) begin
        starts.push_back(cyc);
        got     = '0;
        got[0]  = tx;
        aborted = 1'b0;
        bad_ctl = (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0);
        for (int k = 1; k < 40 && !aborted; k++) begin
          @(negedge clk);
          if (clear === 1'b1) begin
            aborted = 1'b1;
          end else begin
            got[k] = tx;
            if (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) bad_ctl = 1'b1;
          end
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          w = exp_q.pop_front();
          if (!aborted) begin
            chk("frame_ctl", bad_ctl, 1'b0);
            chk("frame_bits", got, frame_bits(w, 4));
            @(negedge clk);
            chk("frame_end", {tx, ready, busy, done}, 4'b1101);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int d0;
    logic [9:0] got1;
    n_vec   = 0;
    n_err   = 0;
    clear   = 1'b1;
    load    = 1'b1;
    data_in = 8'hFF;
    load1   = 1'b1;
    data1   = 8'hFF;

    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset_outs", {tx, ready, busy, done}, 4'b1100);
      chk("reset_outs1", {tx1, ready1, busy1, done1}, 4'b1100);
    end
    clear = 1'b0;
    load  = 1'b0;
    load1 = 1'b0;
    repeat (3) step();
    chk("idle_after_reset", {tx, ready, busy, done}, 4'b1100);
    chk("no_frame_from_reset", starts.size(), 0);

    // Single frame
    d0 = n_done;
    send(8'hA5);
    wait_done("a5", n);
    chk("a5_len", n, 40);
    chk("a5_ready", {ready, busy}, 2'b10);
    chk("a5_done_cnt", n_done - d0, 1);
    step();
    chk("a5_done_pulse", done, 1'b0);

    // Load while busy is ignored
    repeat (3) step();
    d0 = n_done;
    send(8'h3C);
    repeat (11) step();
    data_in = 8'hFF;
    load    = 1'b1;
    step();
    load = 1'b0;
    wait_done("ign", n);
    chk("ign_len", n, 28);
    repeat (5) step();
    chk("ign_done_cnt", n_done - d0, 1);
    chk("ign_idle", {tx, ready, busy, done}, 4'b1100);

    // Back-to-back with load held high
    starts.delete();
    d0      = n_done;
    data_in = 8'h01;
    load    = 1'b1;
    exp_q.push_back(8'h01);
    wait_done("b2b1", n);
    chk("b2b1_len", n, 41);
    data_in = 8'h80;
    exp_q.push_back(8'h80);
    wait_done("b2b2", n);
    chk("b2b2_len", n, 41);
    load = 1'b0;
    repeat (4) step();
    chk("b2b_frames", starts.size(), 2);
    if (starts.size() == 2) chk("b2b_gap", starts[1] - starts[0], 41);
    chk("b2b_done_cnt", n_done - d0, 2);

    // Mid-frame reset
    d0 = n_done;
    send(8'h55);
    repeat (19) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("mid_reset_outs", {tx, ready, busy, done}, 4'b1100);
    repeat (10) step();
    chk("mid_no_done", n_done - d0, 0);
    chk("mid_idle", {tx, ready, busy, done}, 4'b1100);
    d0 = n_done;
    send(8'h0F);
    wait_done("post_reset", n);
    chk("post_reset_len", n, 40);
    chk("post_reset_done_cnt", n_done - d0, 1);

    // BIT_CYCLES=1 instance
    repeat (3) step();
    data1 = 8'hC3;
    load1 = 1'b1;
    step();
    load1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      got1[k] = tx1;
      step();
    end
    chk("bc1_frame", got1, frame_bits(8'hC3, 1) & 40'h3FF);
    chk("bc1_end", {tx1, ready1, busy1, done1}, 4'b1101);
    step();
    chk("bc1_after", {tx1, ready1, busy1, done1}, 4'b1100);

    repeat (5) step();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/output_serializer.md
Name: output_serializer

Overview:
- Transmit end for the SAP output register. Captures an 8-bit word from the W-bus when the controller asserts load.
- Shifts the word out on a single line as a framed serial stream, idle high: one start bit (0), WIDTH data bits LSB-first, one stop bit (1).
- A receiver-side flip-flop chain samples this line. The block is therefore the driver of a registered serial bit stream.

Parameters:
- WIDTH, 8, number of data bits per frame.
- BIT_CYCLES, 4, clk cycles each bit is held on tx (≥1).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- clear  input  1  reset, synchronous, active-high.
- load  input  1  capture request (controller Lo signal); honoured only when ready=1.
- data_in  input  WIDTH  word to transmit, sampled on the accepting edge.
- tx  output  1  serial line, registered; idle 1.
- ready  output  1  high in IDLE; block can accept load.
- busy  output  1  complement of ready.
- done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset: clear=1 at a posedge forces state=IDLE, tx=1, ready=1, busy=0, done=0, shift register=0, bit and cycle counters=0. Takes priority over load. Reset mid-frame aborts the frame immediately with no stop bit.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1. On a posedge with load=1:
  - latch data_in into the shift register;
  - go to START, tx=0 after that edge;
  - ready drops after that edge.
- START: tx=0 held BIT_CYCLES cycles, then DATA with tx=shreg[0].
- DATA: each bit held BIT_CYCLES cycles. After each bit the register shifts right and the bit counter increments. After bit WIDTH-1 completes, go to STOP.
- STOP: tx=1 held BIT_CYCLES cycles, then IDLE.
  - done=1 for exactly the first IDLE cycle, registered.
  - ready=1 from that same cycle.
- Cycle counter: counts 0..BIT_CYCLES-1 and wraps to 0 on each bit boundary. Bit counter width: ceil(log2(WIDTH)) bits, with no overflow past WIDTH-1.
- Frame length: exactly (WIDTH+2)*BIT_CYCLES cycles from the accepting edge to the first IDLE cycle. Default is 40.
- load while busy: ignored. No queuing, no effect on the current frame or shift register.
- data_in changing during a frame: no effect; the captured copy is used.
- Back-to-back: load=1 during the done cycle is accepted. The start bit begins the next cycle, with no idle gap beyond that one cycle.
- load held high continuously: frames repeat with a single IDLE cycle between them.
- BIT_CYCLES=1: one bit per clock, with identical state sequence.

Test Plan:
- Reset: clear=1 for 2 cycles with load=1 and data_in=8'hFF → tx=1, ready=1, busy=0, done=0 throughout; no frame starts.
- Single frame: data_in=8'hA5 with a load pulse.
  - tx sequence per 4-cycle bit: 0 | 1,0,1,0,0,1,0,1 | 1.
  - ready returns after 40 cycles; done pulses once at cycle 40.
- Ignore while busy: load with 8'h3C, then at cycle 12 load with 8'hFF.
  - Line carries 0|0,0,1,1,1,1,0,0|1.
  - Exactly one done pulse.
- Back-to-back: load held high with data_in=8'h01 then 8'h80 on the done cycle.
  - Two frames separated by exactly one tx=1 idle cycle.
  - Second frame data bits 0,0,0,0,0,0,0,1.
- Mid-frame reset: start 8'h55, assert clear at cycle 20 (DATA).
  - tx=1, ready=1 the next cycle; no done pulse.
  - A subsequent load of 8'h0F transmits a correct complete frame.
- BIT_CYCLES=1 build: 8'hC3 → 10-cycle frame 0|1,1,0,0,0,0,1,1|1; done at cycle 10.
